// File: rtl/edge_period_meter.sv
// edge_period_meter: measures high time, low time and period of an asynchronous square wave,
// publishing one result set with a valid strobe per complete input period.
module edge_period_meter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         sig_in,
    output logic [W-1:0] high_cnt,
    output logic [W-1:0] low_cnt,
    output logic [W:0]   period,
    output logic         valid,
    output logic         stuck
);
    typedef enum logic [1:0] {ARM, HIGH, LOW} state_t;
    localparam logic [W-1:0] MAX = '1;

    state_t       state_q, state_d;
    logic         s1_q, s2_q, s3_q;
    logic [W-1:0] cnt_q, cnt_d, cnt_p1;
    logic [W-1:0] hi_tmp_q, hi_tmp_d;
    logic [W-1:0] high_q, high_d, low_q, low_d;
    logic [W:0]   period_q, period_d;
    logic         valid_q, valid_d, stuck_q, stuck_d;
    logic         rise, fall, sat;

    assign rise   = s2_q & ~s3_q;
    assign fall   = ~s2_q & s3_q;
    assign sat    = (cnt_q == MAX) && !(rise || fall);
    assign cnt_p1 = cnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        hi_tmp_d = hi_tmp_q;
        high_d   = high_q;
        low_d    = low_q;
        period_d = period_q;
        valid_d  = 1'b0;
        stuck_d  = stuck_q;
        cnt_d    = (!en || rise || fall) ? '0 : (cnt_q == MAX) ? cnt_q : cnt_p1;
        if (!en) begin
            state_d = ARM;
        end else begin
            case (state_q)
                ARM: if (rise) state_d = HIGH;
                HIGH: begin
                    if (fall) begin
                        hi_tmp_d = cnt_p1;
                        state_d  = LOW;
                    end else if (sat) begin
                        state_d = ARM;
                        stuck_d = 1'b1;
                    end
                end
                LOW: begin
                    // a rise closes this period and opens the next
                    if (rise) begin
                        high_d   = hi_tmp_q;
                        low_d    = cnt_p1;
                        period_d = {1'b0, hi_tmp_q} + {1'b0, cnt_p1};
                        valid_d  = 1'b1;
                        stuck_d  = 1'b0;
                        state_d  = HIGH;
                    end else if (sat) begin
                        state_d = ARM;
                        stuck_d = 1'b1;
                    end
                end
                default: state_d = ARM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            cnt_q    <= '0;
            state_q  <= ARM;
            hi_tmp_q <= '0;
            high_q   <= '0;
            low_q    <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            stuck_q  <= 1'b0;
        end else begin
            s1_q     <= sig_in;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            hi_tmp_q <= hi_tmp_d;
            high_q   <= high_d;
            low_q    <= low_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            stuck_q  <= stuck_d;
        end
    end

    assign high_cnt = high_q;
    assign low_cnt  = low_q;
    assign period   = period_q;
    assign valid    = valid_q;
    assign stuck    = stuck_q;
endmodule

// File: tb/tb_edge_period_meter.sv
// tb_edge_period_meter: scoreboard bench; each completed input period queues its expected
// result when the closing rise is driven, and every valid strobe pops and compares one entry.
module tb_edge_period_meter;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b1;
    logic         sig_in = 1'b0;
    logic [W-1:0] high_cnt, low_cnt;
    logic [W:0]   period;
    logic         valid, stuck;

    int checks = 0, errors = 0;
    int cyc = 0, rise_cyc = 0, nvalid = 0, npush = 0;
    int prev_hi = 0, prev_lo = 0;
    bit offs = 1'b0, prev_ok = 1'b0;
    int q[$];

    edge_period_meter #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
        .high_cnt(high_cnt), .low_cnt(low_cnt), .period(period),
        .valid(valid), .stuck(stuck)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        if (offs) @(negedge clk);
        else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rise_edge();
        sig_in   = 1'b1;
        rise_cyc = cyc;
        if (prev_ok) begin
            q.push_back(prev_hi * 256 + prev_lo);
            npush++;
        end
    endtask

    task automatic pulse(input int hi, input int lo);
        rise_edge();
        repeat (hi) step();
        sig_in = 1'b0;
        repeat (lo) step();
        prev_ok = 1'b1;
        prev_hi = hi;
        prev_lo = lo;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_high"}, int'(high_cnt), 0);
        chk({tag, "_low"}, int'(low_cnt), 0);
        chk({tag, "_period"}, int'(period), 0);
        chk({tag, "_valid"}, int'(valid), 0);
        chk({tag, "_stuck"}, int'(stuck), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && valid) begin
            nvalid++;
            if (q.size() == 0) chk("spurious_valid", 1, 0);
            else begin
                int e;
                e = q.pop_front();
                chk("high_cnt", int'(high_cnt), e / 256);
                chk("low_cnt", int'(low_cnt), e % 256);
                chk("period", int'(period), e / 256 + e % 256);
                chk("stuck_clr", int'(stuck), 0);
                chk("latency", cyc - rise_cyc, 3);
            end
        end
    end

    initial begin
        #2;
        chk_zero("rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (100) step();
        chk_zero("idle");
        // 10/10 square wave driven just after the clock edge
        repeat (5) pulse(10, 10);
        en = 1'b0;
        repeat (30) step();
        chk("en_hold_high", int'(high_cnt), 10);
        chk("en_hold_low", int'(low_cnt), 10);
        chk("en_hold_period", int'(period), 20);
        prev_ok = 1'b0;
        offs = 1'b1;
        en = 1'b1;
        repeat (3) step();
        // 3/7 wave with edges half a clock away from the sampling edge
        repeat (5) pulse(3, 7);
        rise_edge();
        repeat (24) step();
        chk("stuck_set", int'(stuck), 1);
        sig_in = 1'b0;
        repeat (3) step();
        chk("stuck_hold", int'(stuck), 1);
        prev_ok = 1'b0;
        repeat (4) pulse(5, 5);
        rise_edge();
        repeat (5) step();
        sig_in = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        step();
        rst_n = 1'b1;
        repeat (4) step();
        prev_ok = 1'b0;
        repeat (3) pulse(5, 5);
        repeat (10) step();
        chk("queue_empty", q.size(), 0);
        chk("valid_count", nvalid, npush);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
